groestl_msg_pad: RTL and testbench
==================================

// Module: groestl_msg_pad
// PURPOSE
//  Upstream feeder for the Groestl-256 compression core. Accepts a byte-aligned message as 16-bit words.
//  Applies Groestl padding: 0x80 byte, zero fill, then a 64-bit big-endian block count.
//  Shifts each 512-bit block into the core as 32 words on core_ld_msg, then pulses core_start.
//  After the last block, runs the core's output transform with core_fetch / core_load and flags hash_valid.
// PARAMETERS
//  CNT_W  32  block-counter width; the upper (64-CNT_W) bits of the length field are sent as zero
// PORTS
//  clk          in   1   single clock; all logic is on its rising edge
//  rst          in   1   synchronous, active-high reset
//  msg_start    in   1   one-cycle pulse: begin a new message; ignored unless state is IDLE or DONE
//  in_valid     in   1   input word valid
//  in_ready     out  1   block accepts the input word; a word transfers when in_valid & in_ready
//  in_data      in   16  message word, first byte in [15:8]
//  in_last      in   1   final word of the message
//  in_bytes     in   2   valid bytes in the last word: 0, 1 ([15:8] only) or 2; ignored unless in_last
//  core_init    out  1   IV load pulse to the core
//  core_ld_msg  out  1   shift core_idata into the core message register
//  core_idata   out  16  word to the core
//  core_start   out  1   one-cycle compression launch
//  core_fetch   out  1   held high to run the output transform
//  core_load    out  1   one-cycle pulse that clears the core's finalise flag
//  core_busy    in   1   core busy indication
//  hash_valid   out  1   high in DONE; core hash output is stable
//  blk_count    out  CNT_W  blocks compressed for the current message, padding blocks included
// BEHAVIOUR
//  Reset: all outputs and state regs are 0, FSM goes to IDLE. Reset mid-message aborts the message; no partial output.
//  States: IDLE, INIT, INITW, LOAD, PAD80, ZERO, LEN, START, WAIT, FETCH, RELEASE, DONE.
//  IDLE/DONE --msg_start--> INIT: core_init=1 for 1 cycle; blk_count<=0; word index wi<=0; pad flags cleared.
//  INIT -> INITW: 1 idle cycle, because the core registers init. Then INITW -> LOAD.
//  LOAD: in_ready = 1; each accepted word gives core_ld_msg=1 with core_idata=in_data, then wi++.
//   in_last with in_bytes=2: word passes through, then go to PAD80 (0x8000 word pending).
//   in_last with in_bytes=1: core_idata = {in_data[15:8],8'h80}; padded flag set; go to ZERO.
//   in_last with in_bytes=0: no word is shifted; go to PAD80.
//   wi reaching 32 (block full) in any state -> START.
//  PAD80: shift 0x8000 once, set padded, then -> ZERO.
//  ZERO: shift 0x0000 while wi<28. At wi==28 -> LEN. If padded occurred at wi>28, fill to 32 and START,
//   then continue in ZERO on the next block.
//  LEN: shift the 4 words of {(64-CNT_W)'b0, blk_count+1}, MSW first; set final flag.
//  START: core_start=1 for 1 cycle, blk_count++, wi<=0 -> WAIT.
//  WAIT: leave when core_busy==0, at the earliest 2 cycles after START.
//   final -> FETCH; else padded -> ZERO; else -> LOAD.
//  FETCH: core_fetch=1, held. Exit when core_busy==0 on any cycle after the first FETCH cycle -> RELEASE.
//  RELEASE: core_fetch=0 and core_load=1 in the same cycle -> DONE.
//  DONE: hash_valid=1 until msg_start (new message) or rst.
//  Arithmetic: wi is 6 bits and wraps only via START. blk_count saturates at all-ones; no wrap.
//  core_ld_msg never coincides with core_start or core_fetch. in_ready=0 outside LOAD.
//  Simultaneous in_valid and block-full cannot occur: LOAD exits at wi==32 before accepting.
//  Top level ties core rst_n = ~rst.
// TESTING
//  1. Empty msg (in_last, in_bytes=0) -> 1 block; words 0x8000, 27x0, 0,0,0,1; hash equals the software model.
//  2. "abc" (0x6162, 0x63 with bytes=1) -> words 6162, 6380, 26x0, 0,0,0,1; blk_count=1.
//  3. 55-byte msg -> 1 block with 0x80 in the low byte of word 27. 56-byte msg -> 2 blocks; length word = 2.
//  4. 64-byte msg (bytes=2 last) -> block 1 is data, block 2 is 0x8000, zeros, count 2; hash_valid after RELEASE.
//  5. Random in_valid gaps plus rst asserted mid-LOAD -> outputs 0, IDLE; a fresh msg hashes correctly.
//  6. msg_start during WAIT -> ignored; msg_start in DONE -> core_init pulse; hash_valid drops next cycle.

Source files
------------

// File: rtl/groestl_msg_pad.sv
// Groestl-256 message padder and core sequencer.
// Streams 16-bit message words into the compression core, appends the 0x80 byte,
// zero fill and the 64-bit big-endian block count, then drives the output transform.
module groestl_msg_pad #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             msg_start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    input  logic             in_last,
    input  logic [1:0]       in_bytes,
    output logic             core_init,
    output logic             core_ld_msg,
    output logic [15:0]      core_idata,
    output logic             core_start,
    output logic             core_fetch,
    output logic             core_load,
    input  logic             core_busy,
    output logic             hash_valid,
    output logic [CNT_W-1:0] blk_count
);

    typedef enum logic [3:0] {
        S_IDLE, S_INIT, S_INITW, S_LOAD, S_PAD80, S_ZERO,
        S_LEN, S_START, S_WAIT, S_FETCH, S_RELEASE, S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [5:0]         wi_q, wi_d;
    logic [CNT_W-1:0]   blk_q, blk_d;
    logic               padded_q, padded_d;
    logic               pend80_q, pend80_d;
    logic               final_q, final_d;
    logic               stay_q, stay_d;

    logic               full;
    logic [CNT_W-1:0]   blk_inc;
    logic [63:0]        len_field;
    logic [15:0]        len_word;

    assign full      = (wi_q == 6'd32);
    assign blk_inc   = (blk_q == '1) ? blk_q : blk_q + 1'b1;
    assign len_field = 64'(blk_inc);
    assign blk_count = blk_q;

    // Select the length word for the current slot (words 28..31, MSW first).
    always_comb begin
        len_word = '0;
        case (wi_q[1:0])
            2'd0:    len_word = len_field[63:48];
            2'd1:    len_word = len_field[47:32];
            2'd2:    len_word = len_field[31:16];
            default: len_word = len_field[15:0];
        endcase
    end

    // Next-state and output decode.
    // A pending 0x8000 word is remembered in pend80 so that a message ending exactly
    // on a block boundary gets its pad word at the head of the next block.
    always_comb begin
        state_d     = state_q;
        wi_d        = wi_q;
        blk_d       = blk_q;
        padded_d    = padded_q;
        pend80_d    = pend80_q;
        final_d     = final_q;
        in_ready    = 1'b0;
        core_init   = 1'b0;
        core_ld_msg = 1'b0;
        core_idata  = '0;
        core_start  = 1'b0;
        core_fetch  = 1'b0;
        core_load   = 1'b0;
        hash_valid  = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                hash_valid = (state_q == S_DONE);
                if (msg_start) begin
                    state_d  = S_INIT;
                    blk_d    = '0;
                    wi_d     = '0;
                    padded_d = 1'b0;
                    pend80_d = 1'b0;
                    final_d  = 1'b0;
                end
            end
            S_INIT: begin
                core_init = 1'b1;
                state_d   = S_INITW;
            end
            S_INITW: state_d = S_LOAD;
            S_LOAD: begin
                if (full) begin
                    state_d = S_START;
                end else begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        if (!in_last) begin
                            core_ld_msg = 1'b1;
                            core_idata  = in_data;
                        end else begin
                            case (in_bytes)
                                2'd0: begin
                                    pend80_d = 1'b1;
                                    state_d  = S_PAD80;
                                end
                                2'd1: begin
                                    core_ld_msg = 1'b1;
                                    core_idata  = {in_data[15:8], 8'h80};
                                    padded_d    = 1'b1;
                                    state_d     = S_ZERO;
                                end
                                default: begin
                                    core_ld_msg = 1'b1;
                                    core_idata  = in_data;
                                    pend80_d    = 1'b1;
                                    state_d     = S_PAD80;
                                end
                            endcase
                        end
                    end
                end
            end
            S_PAD80: begin
                if (full) begin
                    state_d = S_START;
                end else begin
                    core_ld_msg = 1'b1;
                    core_idata  = 16'h8000;
                    padded_d    = 1'b1;
                    pend80_d    = 1'b0;
                    state_d     = S_ZERO;
                end
            end
            S_ZERO: begin
                if (full) begin
                    state_d = S_START;
                end else if (wi_q == 6'd28) begin
                    state_d = S_LEN;
                end else begin
                    core_ld_msg = 1'b1;
                end
            end
            S_LEN: begin
                if (full) begin
                    state_d = S_START;
                end else begin
                    core_ld_msg = 1'b1;
                    core_idata  = len_word;
                    if (wi_q == 6'd31) final_d = 1'b1;
                end
            end
            S_START: begin
                core_start = 1'b1;
                blk_d      = blk_inc;
                wi_d       = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (stay_q && !core_busy) begin
                    if (final_q)       state_d = S_FETCH;
                    else if (padded_q) state_d = S_ZERO;
                    else if (pend80_q) state_d = S_PAD80;
                    else               state_d = S_LOAD;
                end
            end
            S_FETCH: begin
                core_fetch = 1'b1;
                if (stay_q && !core_busy) state_d = S_RELEASE;
            end
            S_RELEASE: begin
                core_load = 1'b1;
                state_d   = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        if (core_ld_msg) wi_d = wi_q + 6'd1;
    end

    // stay_q is high from the second cycle spent in a state onward.
    always_comb stay_d = (state_d == state_q);

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            wi_q     <= '0;
            blk_q    <= '0;
            padded_q <= 1'b0;
            pend80_q <= 1'b0;
            final_q  <= 1'b0;
            stay_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wi_q     <= wi_d;
            blk_q    <= blk_d;
            padded_q <= padded_d;
            pend80_q <= pend80_d;
            final_q  <= final_d;
            stay_q   <= stay_d;
        end
    end

endmodule

// File: tb/tb_groestl_msg_pad.sv
// Directed bench for groestl_msg_pad: checks the shifted word stream against a
// byte-level Groestl padding model, block counts and the control handshakes.
module tb_groestl_msg_pad;

    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             msg_start = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [15:0]      in_data = '0;
    logic             in_last = 1'b0;
    logic [1:0]       in_bytes = '0;
    logic             core_init, core_ld_msg, core_start, core_fetch, core_load;
    logic [15:0]      core_idata;
    logic             core_busy = 1'b0;
    logic             hash_valid;
    logic [CNT_W-1:0] blk_count;

    groestl_msg_pad #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .msg_start(msg_start),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .in_bytes(in_bytes),
        .core_init(core_init), .core_ld_msg(core_ld_msg), .core_idata(core_idata),
        .core_start(core_start), .core_fetch(core_fetch), .core_load(core_load),
        .core_busy(core_busy), .hash_valid(hash_valid), .blk_count(blk_count)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Core model and stream monitor, sampled on the falling edge.
    logic [15:0] cap[$];
    int n_start = 0, n_init = 0, n_load = 0, viol = 0, bcnt = 0;
    logic fetch_prev = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            bcnt = 0;
            core_busy = 1'b0;
            fetch_prev = 1'b0;
        end else begin
            if (core_ld_msg) begin
                cap.push_back(core_idata);
                if (core_start || core_fetch) viol++;
            end
            if (in_ready && (core_start || core_fetch || core_init || core_load)) viol++;
            if (core_start) begin n_start++; bcnt = 3; end
            if (core_init) n_init++;
            if (core_load) n_load++;
            if (core_fetch && !fetch_prev) bcnt = 3;
            fetch_prev = core_fetch;
            core_busy = (bcnt != 0);
            if (bcnt != 0) bcnt--;
        end
    end

    logic [7:0]  msg[0:255];
    logic [15:0] exp_w[0:255];
    int          exp_n, exp_blk;

    task automatic fill_msg(input int L);
        for (int i = 0; i < L; i++) msg[i] = 8'((i * 37 + 11) & 8'hff);
    endtask

    // Reference padding: msg || 0x80 || 0* || be64(total blocks), length multiple of 64.
    task automatic build_expected(input int L);
        int P;
        logic [63:0] nb;
        logic [7:0] eb[0:511];
        P = L + 1;
        while ((P % 64) != 56) P++;
        P += 8;
        exp_blk = P / 64;
        nb = 64'(exp_blk);
        for (int i = 0; i < P; i++) begin
            if (i < L)           eb[i] = msg[i];
            else if (i == L)     eb[i] = 8'h80;
            else if (i < P - 8)  eb[i] = 8'h00;
            else                 eb[i] = 8'((nb >> (8 * (P - 1 - i))) & 64'hff);
        end
        exp_n = P / 2;
        for (int i = 0; i < exp_n; i++) exp_w[i] = {eb[2*i], eb[2*i+1]};
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [15:0] d, input logic last, input logic [1:0] nbytes,
                             input bit gaps);
        bit done;
        if (gaps) repeat ($urandom_range(0, 2)) tick();
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        in_bytes = nbytes;
        done = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            if (in_ready) done = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!done) begin
            total_cnt++;
            $display("FAIL send_word_timeout: in_ready stayed 0, required 1");
        end
    endtask

    task automatic pulse_start;
        msg_start = 1'b1;
        tick();
        msg_start = 1'b0;
    endtask

    task automatic send_msg(input int L, input bit gaps, input bit trail);
        int nw;
        if (L == 0) begin
            send_word(16'h0000, 1'b1, 2'd0, gaps);
        end else begin
            nw = (L + 1) / 2;
            for (int j = 0; j < nw; j++) begin
                logic [15:0] w;
                logic lst;
                w   = {msg[2*j], (2*j + 1 < L) ? msg[2*j+1] : 8'h00};
                lst = (j == nw - 1) && !trail;
                send_word(w, lst, (L % 2 == 1) ? 2'd1 : 2'd2, gaps);
            end
            if (trail) send_word(16'h0000, 1'b1, 2'd0, gaps);
        end
    endtask

    task automatic wait_done(input string nm);
        for (int c = 0; c < 3000 && !hash_valid; c++) tick();
        total_cnt++;
        if (hash_valid !== 1'b1) $display("FAIL %s_hash_valid: got %b, required 1", nm, hash_valid);
        else pass_cnt++;
    endtask

    // Compare the captured stream and counters since the given snapshot.
    task automatic check_result(input string nm, input int base, input int st0, input int ld0);
        int got_n;
        got_n = cap.size() - base;
        total_cnt++;
        if (got_n !== exp_n) $display("FAIL %s_word_count: got %0d, required %0d", nm, got_n, exp_n);
        else pass_cnt++;
        for (int i = 0; i < exp_n && i < got_n; i++) begin
            total_cnt++;
            if (cap[base + i] !== exp_w[i])
                $display("FAIL %s_word[%0d]: got %h, required %h", nm, i, cap[base + i], exp_w[i]);
            else pass_cnt++;
        end
        total_cnt++;
        if (n_start - st0 !== exp_blk)
            $display("FAIL %s_starts: got %0d, required %0d", nm, n_start - st0, exp_blk);
        else pass_cnt++;
        total_cnt++;
        if (blk_count !== CNT_W'(exp_blk))
            $display("FAIL %s_blk_count: got %0d, required %0d", nm, blk_count, exp_blk);
        else pass_cnt++;
        total_cnt++;
        if (n_load - ld0 !== 1) $display("FAIL %s_core_load: got %0d pulses, required 1", nm, n_load - ld0);
        else pass_cnt++;
    endtask

    task automatic run_msg(input string nm, input int L, input bit gaps, input bit trail);
        int base, st0, ld0;
        build_expected(L);
        base = cap.size();
        st0 = n_start;
        ld0 = n_load;
        pulse_start();
        send_msg(L, gaps, trail);
        wait_done(nm);
        check_result(nm, base, st0, ld0);
    endtask

    task automatic test_reset;
        repeat (3) tick();
        total_cnt++;
        if ({in_ready, core_init, core_ld_msg, core_start, core_fetch, core_load, hash_valid} !== 7'b0)
            $display("FAIL reset_outputs: got %b, required 0000000",
                     {in_ready, core_init, core_ld_msg, core_start, core_fetch, core_load, hash_valid});
        else pass_cnt++;
        total_cnt++;
        if (blk_count !== '0) $display("FAIL reset_blk_count: got %0d, required 0", blk_count);
        else pass_cnt++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_empty;
        run_msg("empty", 0, 1'b0, 1'b0);
    endtask

    task automatic test_abc;
        msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
        run_msg("abc", 3, 1'b0, 1'b0);
        total_cnt++;
        if (exp_w[1] !== 16'h6380 || cap[cap.size() - 32 + 1] !== 16'h6380)
            $display("FAIL abc_word1: got %h, required 6380", cap[cap.size() - 32 + 1]);
        else pass_cnt++;
    endtask

    task automatic test_boundaries;
        fill_msg(64);
        run_msg("len55", 55, 1'b0, 1'b0);
        run_msg("len56", 56, 1'b0, 1'b0);
        run_msg("len64", 64, 1'b0, 1'b0);
        run_msg("len64_trail", 64, 1'b1, 1'b1);
        run_msg("len57", 57, 1'b1, 1'b0);
    endtask

    task automatic test_abort;
        int init0;
        fill_msg(40);
        pulse_start();
        for (int j = 0; j < 5; j++) send_word({msg[2*j], msg[2*j+1]}, 1'b0, 2'd2, 1'b1);
        rst = 1'b1;
        tick();
        total_cnt++;
        if ({in_ready, core_ld_msg, core_start, core_fetch, hash_valid} !== 5'b0 || blk_count !== '0)
            $display("FAIL abort_outputs: got %b cnt %0d, required 00000 cnt 0",
                     {in_ready, core_ld_msg, core_start, core_fetch, hash_valid}, blk_count);
        else pass_cnt++;
        rst = 1'b0;
        tick();
        tick();
        total_cnt++;
        if (in_ready !== 1'b0) $display("FAIL abort_idle_ready: got %b, required 0", in_ready);
        else pass_cnt++;
        init0 = n_init;
        run_msg("after_abort", 33, 1'b1, 1'b0);
        total_cnt++;
        if (n_init - init0 !== 1) $display("FAIL after_abort_init: got %0d pulses, required 1", n_init - init0);
        else pass_cnt++;
    endtask

    task automatic test_start_ignored;
        int init0, st0;
        init0 = n_init;
        st0 = n_start;
        fill_msg(20);
        fork
            run_msg("wait_start", 20, 1'b0, 1'b0);
            begin
                for (int c = 0; c < 500 && n_start == st0; c++) tick();
                msg_start = 1'b1;
                tick();
                msg_start = 1'b0;
            end
        join
        total_cnt++;
        if (n_init - init0 !== 1) $display("FAIL wait_start_init: got %0d pulses, required 1", n_init - init0);
        else pass_cnt++;
        msg_start = 1'b1;
        total_cnt++;
        if (hash_valid !== 1'b1 || core_init !== 1'b0)
            $display("FAIL done_before_start: got hv=%b init=%b, required hv=1 init=0", hash_valid, core_init);
        else pass_cnt++;
        tick();
        msg_start = 1'b0;
        total_cnt++;
        if (hash_valid !== 1'b0 || core_init !== 1'b1 || blk_count !== '0)
            $display("FAIL done_restart: got hv=%b init=%b cnt=%0d, required hv=0 init=1 cnt=0",
                     hash_valid, core_init, blk_count);
        else pass_cnt++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_protocol;
        total_cnt++;
        if (viol !== 0) $display("FAIL protocol_overlap: got %0d violations, required 0", viol);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_empty();
        test_abc();
        test_boundaries();
        test_abort();
        test_start_ignored();
        test_protocol();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
